// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
package hazard_pkg;

  // Result latencies, counted in cycles after E
  localparam int unsigned LAT_ALU  = 1;
  localparam int unsigned LAT_LOAD = 2;
  localparam int unsigned LAT_MUL  = 3;

  // Forward-select encoding: 0 selects the register-file value
  localparam int unsigned FWD_RF = 0;

  // Storage widths for shadow fields. Ports are zero-extended into these,
  // so REG_AW must not exceed SHADOW_AW and LAT_W must not exceed SHADOW_LW.
  localparam int unsigned SHADOW_AW = 8;
  localparam int unsigned SHADOW_LW = 4;

  typedef struct packed {
    logic                 valid;
    logic [SHADOW_AW-1:0] rd;
    logic                 regwrite;
    logic [SHADOW_LW-1:0] lat;
    logic [SHADOW_AW-1:0] rs1;
    logic [SHADOW_AW-1:0] rs2;
    logic                 use1;
    logic                 use2;
  } shadow_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against the tracked shadow stages and
// reports a D-side hazard, the E-side forward tap, and whether the
// youngest matching producer is still not ready.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int MAX_LAT = 3,
  parameter int FWD_W   = $clog2(MAX_LAT + 1)
) (
  input  logic [SHADOW_AW-1:0]               src,
  input  logic                               use_src,
  input  logic [MAX_LAT-1:0]                 live,
  input  logic [MAX_LAT-1:0][SHADOW_AW-1:0]  rd,
  input  logic [MAX_LAT-1:0][SHADOW_LW-1:0]  lat,
  output logic                               hazard,
  output logic [FWD_W-1:0]                   fwd_idx,
  output logic                               pending
);

  // Scan stages; descending loops let the youngest (smallest k) win.
  always_comb begin
    hazard  = 1'b0;
    fwd_idx = FWD_W'(FWD_RF);
    pending = 1'b0;
    if (use_src && (src != '0)) begin
      for (int unsigned k = 0; k < MAX_LAT; k++) begin
        if (live[k] && (rd[k] == src) && (SHADOW_LW'(k + 1) < lat[k]))
          hazard = 1'b1;
      end
      for (int unsigned k = MAX_LAT - 1; k >= 1; k--) begin
        if (live[k] && (rd[k] == src)) begin
          pending = (SHADOW_LW'(k) < lat[k]);
          if (SHADOW_LW'(k) >= lat[k])
            fwd_idx = FWD_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Parametrised hazard/forwarding controller: shadow pipeline of in-flight
// destinations, load-use stall, branch flush and N-way forward selects.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 3,
  parameter int LAT_W   = $clog2(MAX_LAT + 1),
  parameter int FWD_W   = $clog2(MAX_LAT + 1),
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic              UseRs1D,
  input  logic              UseRs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic [LAT_W-1:0]  LatD,
  input  logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [FWD_W-1:0]  ForwardAE,
  output logic [FWD_W-1:0]  ForwardBE,
  output logic [CNT_W-1:0]  StallCount
);

  // Only S0..S_{MAX_LAT-1} are stored: the writeback stage S_MAX_LAT never
  // stalls or forwards because the register file is write-first.
  shadow_t [MAX_LAT-1:0] shadow_q, shadow_d;
  logic    [CNT_W-1:0]   count_q, count_d;

  logic [MAX_LAT-1:0]                live;
  logic [MAX_LAT-1:0][SHADOW_AW-1:0] rd_vec;
  logic [MAX_LAT-1:0][SHADOW_LW-1:0] lat_vec;
  logic [LAT_W-1:0]                  lat_eff;
  logic                              lat_legal;
  logic                              stall;
  logic                              haz_d1, haz_d2, haz_e1, haz_e2;
  logic                              pend_d1, pend_d2, pend_e1, pend_e2;
  logic [FWD_W-1:0]                  fwd_d1, fwd_d2, fwd_e1, fwd_e2;
  logic                              unused_fold;

  // Flatten the shadow entries into the per-stage vectors the matchers scan
  always_comb begin
    live    = '0;
    rd_vec  = '0;
    lat_vec = '0;
    for (int unsigned k = 0; k < MAX_LAT; k++) begin
      live[k]    = shadow_q[k].valid && shadow_q[k].regwrite && (shadow_q[k].rd != '0);
      rd_vec[k]  = shadow_q[k].rd;
      lat_vec[k] = shadow_q[k].lat;
    end
  end

  hazard_match #(.MAX_LAT(MAX_LAT), .FWD_W(FWD_W)) u_match_d1 (
    .src(SHADOW_AW'(Rs1D)), .use_src(UseRs1D), .live(live), .rd(rd_vec),
    .lat(lat_vec), .hazard(haz_d1), .fwd_idx(fwd_d1), .pending(pend_d1)
  );

  hazard_match #(.MAX_LAT(MAX_LAT), .FWD_W(FWD_W)) u_match_d2 (
    .src(SHADOW_AW'(Rs2D)), .use_src(UseRs2D), .live(live), .rd(rd_vec),
    .lat(lat_vec), .hazard(haz_d2), .fwd_idx(fwd_d2), .pending(pend_d2)
  );

  hazard_match #(.MAX_LAT(MAX_LAT), .FWD_W(FWD_W)) u_match_e1 (
    .src(shadow_q[0].rs1), .use_src(shadow_q[0].valid && shadow_q[0].use1),
    .live(live), .rd(rd_vec), .lat(lat_vec),
    .hazard(haz_e1), .fwd_idx(fwd_e1), .pending(pend_e1)
  );

  hazard_match #(.MAX_LAT(MAX_LAT), .FWD_W(FWD_W)) u_match_e2 (
    .src(shadow_q[0].rs2), .use_src(shadow_q[0].valid && shadow_q[0].use2),
    .live(live), .rd(rd_vec), .lat(lat_vec),
    .hazard(haz_e2), .fwd_idx(fwd_e2), .pending(pend_e2)
  );

  // Stall/flush/forward outputs; a taken branch overrides the stall
  always_comb begin
    stall     = haz_d1 || haz_d2;
    StallF    = stall && !PCSrcE;
    StallD    = stall && !PCSrcE;
    FlushD    = PCSrcE;
    FlushE    = stall || PCSrcE;
    ForwardAE = fwd_e1;
    ForwardBE = fwd_e2;
  end

  // Out-of-range latencies are clamped to the deepest stage
  always_comb begin
    lat_legal = (LatD != '0) && (LatD <= LAT_W'(MAX_LAT));
    lat_eff   = lat_legal ? LatD : LAT_W'(MAX_LAT);
  end

  // Next shadow state: shift every stage, load S0 from D or a bubble
  always_comb begin
    shadow_d = '0;
    for (int unsigned k = 1; k < MAX_LAT; k++)
      shadow_d[k] = shadow_q[k-1];
    if (!FlushE) begin
      shadow_d[0].valid    = 1'b1;
      shadow_d[0].rd       = SHADOW_AW'(RdD);
      shadow_d[0].regwrite = RegWriteD;
      shadow_d[0].lat      = SHADOW_LW'(lat_eff);
      shadow_d[0].rs1      = SHADOW_AW'(Rs1D);
      shadow_d[0].rs2      = SHADOW_AW'(Rs2D);
      shadow_d[0].use1     = UseRs1D;
      shadow_d[0].use2     = UseRs2D;
    end
  end

  // Saturating load-use stall counter
  always_comb begin
    count_d = count_q;
    if (StallD && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  assign StallCount = count_q;

  // Shadow pipeline and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  // Results that only the D-side or only the E-side matchers need
  always_comb begin
    unused_fold = ^{fwd_d1, fwd_d2, pend_d1, pend_d2, haz_e1, haz_e2};
    for (int unsigned k = 1; k < MAX_LAT; k++)
      unused_fold = unused_fold ^ (^{shadow_q[k].rs1, shadow_q[k].rs2,
                                     shadow_q[k].use1, shadow_q[k].use2});
  end

  // Protocol checks: illegal latency and an unready producer reaching E
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (lat_legal)
        else $error("hazard_scoreboard: illegal LatD %0d", LatD);
      assert (!(pend_e1 || pend_e2))
        else $error("hazard_scoreboard: E consumer reached unready producer");
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       UseRs1D, UseRs2D, RegWriteD, PCSrcE;
  logic [1:0] LatD;
  logic [2:0] LatD4;

  logic        StallF, StallD, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCount;

  logic        StallF4, StallD4, FlushD4, FlushE4;
  logic [2:0]  ForwardAE4, ForwardBE4;
  logic [31:0] StallCount4;

  logic [7:0]  vec;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_cnt = '0;

  localparam logic [7:0] V_IDLE  = 8'b0000_0000;
  localparam logic [7:0] V_STALL = 8'b1101_0000;
  localparam logic [7:0] V_BR    = 8'b0011_0000;

  always #5 clk = ~clk;

  assign LatD4 = {1'b0, LatD};
  assign vec   = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};

  hazard_scoreboard #(.REG_AW(5), .MAX_LAT(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D),
    .UseRs2D(UseRs2D), .RdD(RdD), .RegWriteD(RegWriteD), .LatD(LatD),
    .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCount(StallCount)
  );

  hazard_scoreboard #(.REG_AW(5), .MAX_LAT(4), .CNT_W(32)) dut4 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D),
    .UseRs2D(UseRs2D), .RdD(RdD), .RegWriteD(RegWriteD), .LatD(LatD4),
    .PCSrcE(PCSrcE), .StallF(StallF4), .StallD(StallD4), .FlushD(FlushD4),
    .FlushE(FlushE4), .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4),
    .StallCount(StallCount4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic [4:0] rd, input logic we, input logic [1:0] lat);
    Rs1D = rs1; Rs2D = rs2; UseRs1D = u1; UseRs2D = u2;
    RdD = rd; RegWriteD = we; LatD = lat;
  endtask

  task automatic nop();
    set_d(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd1);
  endtask

  task automatic drain();
    nop();
    PCSrcE = 1'b0;
    repeat (5) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0; PCSrcE = 1'b0; nop();
    repeat (3) cyc();
    #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL reset_vec got=%b exp=%b", vec, V_IDLE); end
    total++; if (StallCount !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", StallCount); end
    reset = 1'b1;
    cyc(); #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL reset_rel_vec got=%b exp=%b", vec, V_IDLE); end
    total++; if ({ForwardAE4, ForwardBE4, StallD4} !== 7'd0) begin bad++; $display("FAIL reset_dut4 got=%b exp=0", {ForwardAE4, ForwardBE4, StallD4}); end
  endtask

  task automatic test_alu();
    drain();
    set_d(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 2'd1); #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL alu_c0 got=%b exp=%b", vec, V_IDLE); end
    cyc();
    set_d(5'd5, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 2'd1); #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL alu_nostall got=%b exp=%b", vec, V_IDLE); end
    cyc();
    nop(); #2;
    total++; if (vec !== 8'b0000_0100) begin bad++; $display("FAIL alu_fwd1 got=%b exp=00000100", vec); end
    total++; if (ForwardAE4 !== 3'd1) begin bad++; $display("FAIL alu_fwd1_dut4 got=%0d exp=1", ForwardAE4); end
    cyc();
    set_d(5'd5, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 2'd1); #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL alu_late_d got=%b exp=%b", vec, V_IDLE); end
    cyc();
    nop(); #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL alu_late_e got=%b exp=%b", vec, V_IDLE); end
    total++; if (ForwardAE4 !== 3'd3) begin bad++; $display("FAIL alu_late_dut4 got=%0d exp=3", ForwardAE4); end
  endtask

  task automatic test_load();
    drain();
    set_d(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 2'd2);
    cyc();
    set_d(5'd0, 5'd6, 1'b0, 1'b1, 5'd12, 1'b1, 2'd1); #2;
    total++; if (vec !== V_STALL) begin bad++; $display("FAIL load_stall got=%b exp=%b", vec, V_STALL); end
    cyc(); exp_cnt = exp_cnt + 1;
    total++; if (StallCount !== exp_cnt) begin bad++; $display("FAIL load_cnt got=%0d exp=%0d", StallCount, exp_cnt); end
    #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL load_release got=%b exp=%b", vec, V_IDLE); end
    cyc();
    nop(); #2;
    total++; if (vec !== 8'b0000_0010) begin bad++; $display("FAIL load_fwdB got=%b exp=00000010", vec); end
    total++; if (StallCount !== exp_cnt) begin bad++; $display("FAIL load_cnt2 got=%0d exp=%0d", StallCount, exp_cnt); end
  endtask

  task automatic test_mul();
    drain();
    set_d(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 2'd3);
    cyc();
    set_d(5'd7, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 2'd1); #2;
    total++; if (vec !== V_STALL) begin bad++; $display("FAIL mul_stall1 got=%b exp=%b", vec, V_STALL); end
    cyc(); exp_cnt = exp_cnt + 1; #2;
    total++; if (vec !== V_STALL) begin bad++; $display("FAIL mul_stall2 got=%b exp=%b", vec, V_STALL); end
    cyc(); exp_cnt = exp_cnt + 1; #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL mul_release got=%b exp=%b", vec, V_IDLE); end
    total++; if (StallCount !== exp_cnt) begin bad++; $display("FAIL mul_cnt got=%0d exp=%0d", StallCount, exp_cnt); end
    cyc();
    nop(); #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL mul_wb_rf got=%b exp=%b", vec, V_IDLE); end
    total++; if (ForwardAE4 !== 3'd3) begin bad++; $display("FAIL mul_fwd3_dut4 got=%0d exp=3", ForwardAE4); end
  endtask

  task automatic test_branch();
    drain();
    set_d(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 2'd2);
    cyc();
    set_d(5'd6, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 2'd1);
    PCSrcE = 1'b1; #2;
    total++; if (vec !== V_BR) begin bad++; $display("FAIL br_priority got=%b exp=%b", vec, V_BR); end
    cyc();
    PCSrcE = 1'b0; nop(); #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL br_after got=%b exp=%b", vec, V_IDLE); end
    total++; if (StallCount !== exp_cnt) begin bad++; $display("FAIL br_cnt got=%0d exp=%0d", StallCount, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    drain();
    set_d(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 2'd1);
    cyc();
    set_d(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 2'd2); #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL b2b_prod got=%b exp=%b", vec, V_IDLE); end
    cyc();
    set_d(5'd8, 5'd8, 1'b1, 1'b1, 5'd15, 1'b1, 2'd1); #2;
    total++; if (vec !== V_STALL) begin bad++; $display("FAIL b2b_stall got=%b exp=%b", vec, V_STALL); end
    cyc(); exp_cnt = exp_cnt + 1; #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL b2b_release got=%b exp=%b", vec, V_IDLE); end
    cyc();
    nop(); #2;
    total++; if (vec !== 8'b0000_1010) begin bad++; $display("FAIL b2b_fwd got=%b exp=00001010", vec); end
    total++; if ({ForwardAE4, ForwardBE4} !== 6'b010_010) begin bad++; $display("FAIL b2b_youngest_dut4 got=%b exp=010010", {ForwardAE4, ForwardBE4}); end
    total++; if (StallCount !== exp_cnt) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", StallCount, exp_cnt); end
  endtask

  task automatic test_x0();
    drain();
    set_d(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 2'd3);
    cyc();
    set_d(5'd0, 5'd0, 1'b1, 1'b1, 5'd16, 1'b1, 2'd1); #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL x0_nostall got=%b exp=%b", vec, V_IDLE); end
    cyc();
    nop(); #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL x0_nofwd got=%b exp=%b", vec, V_IDLE); end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_d(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 2'd2);
    cyc();
    set_d(5'd9, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 2'd1); #2;
    total++; if (vec !== V_STALL) begin bad++; $display("FAIL rst_pre got=%b exp=%b", vec, V_STALL); end
    reset = 1'b0; #1;
    exp_cnt = '0;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL rst_mid_vec got=%b exp=%b", vec, V_IDLE); end
    total++; if (StallCount !== exp_cnt) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", StallCount); end
    total++; if (StallD4 !== 1'b0) begin bad++; $display("FAIL rst_mid_dut4 got=%b exp=0", StallD4); end
    cyc(); #2;
    reset = 1'b1;
    cyc(); #2;
    total++; if (vec !== V_IDLE) begin bad++; $display("FAIL rst_after got=%b exp=%b", vec, V_IDLE); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_mul();
    test_branch();
    test_back_to_back();
    test_x0();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
